// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding and size/legality helpers
// shared by the lsu_master block and its lane aligner.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_RESP
    } state_t;

    // Access size in bytes (1, 2 or 4) from funct3.
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        logic [2:0] sz;
        case (f3[1:0])
            2'b00:   sz = 3'd1;
            2'b01:   sz = 3'd2;
            default: sz = 3'd4;
        endcase
        return sz;
    endfunction

    // Stores only come in B/H/W flavours; loads add the unsigned forms.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we)
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        return ok;
    endfunction

endpackage

// File: rtl/lsu_master_if.sv
// lsu_master_if: core request/response and word-memory bus of the LSU.
// master = the LSU itself, slave = core plus memory side.
interface lsu_master_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load extract/extend and store byte-lane merge over a
// little-endian two-word window {word1, word0}.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [63:0] merged
);
    logic [63:0] pair;
    logic [5:0]  shamt;
    logic [31:0] shifted;
    logic [63:0] base_mask;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;

    assign pair  = {word1, word0};
    assign shamt = {1'b0, offset, 3'b000};

    // Shift the window down to the addressed byte, then size and extend.
    always_comb begin
        shifted = 32'(pair >> shamt);
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // Replace lanes offset..offset+size-1, spilling into word1 if needed.
    always_comb begin
        case (size_of(funct3))
            3'd1:    base_mask = 64'h0000_0000_0000_00ff;
            3'd2:    base_mask = 64'h0000_0000_0000_ffff;
            default: base_mask = 64'h0000_0000_ffff_ffff;
        endcase
        lane_mask = base_mask << shamt;
        lane_data = ({32'h0, wdata} & base_mask) << shamt;
        merged    = (pair & ~lane_mask) | lane_data;
    end

endmodule

// File: rtl/lsu_master.sv
// lsu_master: byte-addressed RV32 load/store to word memory, with RMW
// sub-word stores. LSU_MISALIGN_EN enables splitting word-crossing accesses.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input logic          clk,
    input logic          rst,
    lsu_master_if.master bus
);
`ifdef LSU_MISALIGN_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word0_q, word0_d;
    logic [31:0]       word1_q, word1_d;
    logic              cross_q, cross_d;
    logic              err_q, err_d;

    logic [1:0]        req_off;
    logic [2:0]        req_size;
    logic              req_cross;
    logic              req_full;
    logic              req_bad;
    logic [ADDR_W-1:0] widx_nx;
    logic [31:0]       load_data;
    logic [63:0]       merged;
    logic              unused_addr_hi;

    assign req_off   = bus.req_addr[1:0];
    assign req_size  = size_of(bus.req_funct3);
    assign req_cross = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
    assign req_full  = bus.req_we && (req_size == 3'd4) &&
                       (req_off == 2'b00);
    assign req_bad   = !is_legal(bus.req_we, bus.req_funct3) ||
                       (req_cross && !SPLIT_EN);
    assign widx_nx   = widx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    lsu_lane_align u_align (
        .funct3    (f3_q),
        .offset    (off_q),
        .word0     (word0_q),
        .word1     (word1_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            widx_q  <= '0;
            wdata_q <= 32'h0;
            word0_q <= 32'h0;
            word1_q <= 32'h0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            cross_q <= cross_d;
            err_q   <= err_d;
        end
    end

    // Next state: latch on accept, capture read words, sequence writes.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        word0_d = word0_q;
        word1_d = word1_q;
        cross_d = cross_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    off_d   = req_off;
                    widx_d  = bus.req_addr[ADDR_W+1:2];
                    wdata_d = bus.req_wdata;
                    cross_d = req_cross;
                    err_d   = req_bad;
                    if (req_bad)
                        state_d = S_RESP;
                    else if (req_full)
                        state_d = S_WR0;
                    else
                        state_d = S_RD0;
                end
            end
            S_RD0: begin
                word0_d = bus.mem_rdata;
                if (cross_q)
                    state_d = S_RD1;
                else if (we_q)
                    state_d = S_WR0;
                else
                    state_d = S_RESP;
            end
            S_RD1: begin
                word1_d = bus.mem_rdata;
                state_d = we_q ? S_WR0 : S_RESP;
            end
            S_WR0:  state_d = cross_q ? S_WR1 : S_RESP;
            S_WR1:  state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state so reset clears them immediately.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = 32'h0;
        bus.resp_err   = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_we     = 1'b0;
        bus.mem_wdata  = 32'h0;
        unique case (state_q)
            S_IDLE: bus.req_ready = 1'b1;
            S_RD0:  bus.mem_addr  = widx_q;
            S_RD1:  bus.mem_addr  = widx_nx;
            S_WR0: begin
                bus.mem_addr  = widx_q;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = merged[31:0];
            end
            S_WR1: begin
                bus.mem_addr  = widx_nx;
                bus.mem_we    = 1'b1;
                bus.mem_wdata = merged[63:32];
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                if (!err_q && !we_q)
                    bus.resp_rdata = load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed checks of lsu_master against a word memory
// model; crossing expectations follow LSU_MISALIGN_EN.
module tb_lsu_master;

    localparam int AW = 14;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [31:0] mem [0:(1<<AW)-1];

    lsu_master_if #(.ADDR_W(AW)) bus ();

    lsu_master #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk)
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

    // Drive one request in an IDLE cycle, then watch until resp_valid.
    // lat counts cycles from the handshake edge; 99 marks a timeout.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd,
                         output logic er, output int wes);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hdead_beef;
        bus.req_wdata  = 32'hffff_ffff;
        lat = 0;
        wes = 0;
        rd  = 32'hx;
        er  = 1'bx;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.mem_we) wes++;
            if (bus.resp_valid) begin
                rd = bus.resp_rdata;
                er = bus.resp_err;
                break;
            end
            if (lat >= 20) begin
                lat = 99;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready got %b want 1", bus.req_ready);
        end
        n_cmp++;
        if (bus.resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_resp_valid got %b want 0", bus.resp_valid);
        end
        n_cmp++;
        if (bus.resp_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata got %h want 0", bus.resp_rdata);
        end
        n_cmp++;
        if (bus.resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_err got %b want 0", bus.resp_err);
        end
        n_cmp++;
        if (bus.mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mem_we got %b want 0", bus.mem_we);
        end
        n_cmp++;
        if (bus.mem_addr !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr);
        end
        n_cmp++;
        if (bus.mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_load();
        int lat, wes;
        logic [31:0] rd;
        logic er;
        logic [2:0]  f3v [6];
        logic [31:0] adv [6];
        logic [31:0] exv [6];
        f3v = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001};
        adv = '{32'h15, 32'h15, 32'h16, 32'h16, 32'h14, 32'h15};
        exv = '{32'hffff_ffaa, 32'h0000_00aa, 32'hffff_8899,
                32'h0000_8899, 32'h8899_aabb, 32'hffff_99aa};
        mem[5] = 32'h8899_aabb;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, f3v[i], adv[i], 32'h0, lat, rd, er, wes);
            n_cmp++;
            if (rd !== exv[i] || er !== 1'b0) begin
                n_bad++;
                $display("FAIL load_%0d data got %h/%b want %h/0",
                         i, rd, er, exv[i]);
            end
            n_cmp++;
            if (lat !== 2 || wes !== 0) begin
                n_bad++;
                $display("FAIL load_%0d timing got lat %0d we %0d want 2 0",
                         i, lat, wes);
            end
        end
    endtask

    task automatic test_store_word();
        int lat, wes;
        logic [31:0] rd;
        logic er;
        mem[8] = 32'h0;
        issue(1'b1, 3'b010, 32'h20, 32'h1234_5678, lat, rd, er, wes);
        @(posedge clk);
        #1;
        n_cmp++;
        if (mem[8] !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL sw_mem got %h want 12345678", mem[8]);
        end
        n_cmp++;
        if (lat !== 2 || wes !== 1) begin
            n_bad++;
            $display("FAIL sw_timing got lat %0d we %0d want 2 1", lat, wes);
        end
        n_cmp++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_resp got %h/%b want 0/0", rd, er);
        end
    endtask

    task automatic test_store_sub();
        int lat, wes;
        logic [31:0] rd;
        logic er;
        mem[3] = 32'h1122_3344;
        issue(1'b1, 3'b000, 32'h0e, 32'h0000_00ee, lat, rd, er, wes);
        n_cmp++;
        if (mem[3] !== 32'h11ee_3344) begin
            n_bad++;
            $display("FAIL sb_mem got %h want 11ee3344", mem[3]);
        end
        n_cmp++;
        if (lat !== 3 || wes !== 1) begin
            n_bad++;
            $display("FAIL sb_timing got lat %0d we %0d want 3 1", lat, wes);
        end
        issue(1'b1, 3'b001, 32'h0c, 32'hffff_abcd, lat, rd, er, wes);
        n_cmp++;
        if (mem[3] !== 32'h11ee_abcd) begin
            n_bad++;
            $display("FAIL sh_mem got %h want 11eeabcd", mem[3]);
        end
        n_cmp++;
        if (lat !== 3 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL sh_timing got lat %0d err %b want 3 0", lat, er);
        end
    endtask

    task automatic test_misalign();
        int lat, wes;
        logic [31:0] rd;
        logic er;
        mem[1] = 32'hddcc_bbaa;
        mem[2] = 32'h4433_2211;
        issue(1'b0, 3'b010, 32'h07, 32'h0, lat, rd, er, wes);
`ifdef LSU_MISALIGN_EN
        n_cmp++;
        if (rd !== 32'h3322_11dd || er !== 1'b0 || lat !== 3) begin
            n_bad++;
            $display("FAIL lw_cross got %h/%b lat %0d want 332211dd/0 3",
                     rd, er, lat);
        end
`else
        n_cmp++;
        if (rd !== 32'h0 || er !== 1'b1 || lat !== 1 || wes !== 0) begin
            n_bad++;
            $display("FAIL lw_cross got %h/%b lat %0d we %0d want 0/1 1 0",
                     rd, er, lat, wes);
        end
`endif
        mem[3] = 32'h5566_7788;
        issue(1'b1, 3'b001, 32'h0b, 32'h0000_beef, lat, rd, er, wes);
`ifdef LSU_MISALIGN_EN
        n_cmp++;
        if (mem[2] !== 32'hef33_2211 || mem[3] !== 32'h5566_77be) begin
            n_bad++;
            $display("FAIL sh_cross_mem got %h %h want ef332211 556677be",
                     mem[2], mem[3]);
        end
        n_cmp++;
        if (lat !== 5 || wes !== 2 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL sh_cross_timing got lat %0d we %0d err %b want 5 2 0",
                     lat, wes, er);
        end
`else
        n_cmp++;
        if (mem[2] !== 32'h4433_2211 || mem[3] !== 32'h5566_7788) begin
            n_bad++;
            $display("FAIL sh_cross_mem got %h %h want 44332211 55667788",
                     mem[2], mem[3]);
        end
        n_cmp++;
        if (lat !== 1 || wes !== 0 || er !== 1'b1) begin
            n_bad++;
            $display("FAIL sh_cross_timing got lat %0d we %0d err %b want 1 0 1",
                     lat, wes, er);
        end
`endif
        mem[16383] = 32'ha1b2_c3d4;
        mem[0]     = 32'h0f1e_2d3c;
        issue(1'b0, 3'b010, 32'hfffe, 32'h0, lat, rd, er, wes);
`ifdef LSU_MISALIGN_EN
        n_cmp++;
        if (rd !== 32'h2d3c_a1b2 || er !== 1'b0 || lat !== 3) begin
            n_bad++;
            $display("FAIL lw_wrap got %h/%b lat %0d want 2d3ca1b2/0 3",
                     rd, er, lat);
        end
`else
        n_cmp++;
        if (rd !== 32'h0 || er !== 1'b1 || lat !== 1) begin
            n_bad++;
            $display("FAIL lw_wrap got %h/%b lat %0d want 0/1 1", rd, er, lat);
        end
`endif
        issue(1'b0, 3'b000, 32'hffff, 32'h0, lat, rd, er, wes);
        n_cmp++;
        if (rd !== 32'hffff_ffa1 || er !== 1'b0 || lat !== 2) begin
            n_bad++;
            $display("FAIL lb_last got %h/%b lat %0d want ffffffa1/0 2",
                     rd, er, lat);
        end
    endtask

    task automatic test_error();
        int lat, wes;
        logic [31:0] rd;
        logic er;
        mem[5] = 32'h8899_aabb;
        issue(1'b0, 3'b011, 32'h14, 32'h0, lat, rd, er, wes);
        n_cmp++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            n_bad++;
            $display("FAIL err_load got %h/%b want 0/1", rd, er);
        end
        n_cmp++;
        if (lat !== 1 || wes !== 0) begin
            n_bad++;
            $display("FAIL err_load_timing got lat %0d we %0d want 1 0",
                     lat, wes);
        end
        issue(1'b1, 3'b100, 32'h14, 32'h0000_0055, lat, rd, er, wes);
        @(posedge clk);
        #1;
        n_cmp++;
        if (er !== 1'b1 || wes !== 0 || mem[5] !== 32'h8899_aabb) begin
            n_bad++;
            $display("FAIL err_store got err %b we %0d mem %h want 1 0 8899aabb",
                     er, wes, mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        int lat, wes;
        logic [31:0] rd;
        logic er;
        mem[9]  = 32'hcafe_0001;
        mem[10] = 32'hcafe_0002;
        issue(1'b0, 3'b010, 32'h24, 32'h0, lat, rd, er, wes);
        n_cmp++;
        if (rd !== 32'hcafe_0001 || lat !== 2) begin
            n_bad++;
            $display("FAIL b2b_first got %h lat %0d want cafe0001 2", rd, lat);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle got ready %b valid %b want 1 0",
                     bus.req_ready, bus.resp_valid);
        end
        issue(1'b0, 3'b010, 32'h28, 32'h0, lat, rd, er, wes);
        n_cmp++;
        if (rd !== 32'hcafe_0002 || lat !== 2) begin
            n_bad++;
            $display("FAIL b2b_second got %h lat %0d want cafe0002 2", rd, lat);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        mem[16] = 32'h0102_0304;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'hcafe_f00d;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n_cmp++;
        if (bus.mem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_wr0 got mem_we %b want 1", bus.mem_we);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.mem_we !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_async got we %b ready %b want 0 1",
                     bus.mem_we, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || mem[16] !== 32'h0102_0304) begin
            n_bad++;
            $display("FAIL rstmid_after got pulses %0d mem %h want 0 01020304",
                     pulses, mem[16]);
        end
    endtask

    initial begin
        clk            = 1'b0;
        rst            = 1'b0;
        n_cmp          = 0;
        n_bad          = 0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        test_reset();
        test_load();
        test_store_word();
        test_store_sub();
        test_misalign();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
